// File: rtl/fetch_unit.sv
// Instruction fetch: sequential PC, one outstanding icache read, {pc,inst} FIFO toward decode; redirects flush.
// Build option FETCH_ALIGN_CHECK_EN: misaligned PCs push an address-error entry (out_adel) and halt fetch.
module fetch_unit #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    FIFO_DEPTH_LOG2 = 3,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC        = 32'hbfc00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  icache_read_en,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic                  icache_ready,
  input  logic [DATA_WIDTH-1:0] icache_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [DATA_WIDTH-1:0] out_inst
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                  out_adel
`endif
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CW    = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] inst;
`ifdef FETCH_ALIGN_CHECK_EN
    logic                  adel;
`endif
  } entry_t;

  state_t                     state, state_nxt;
  logic [ADDR_WIDTH-1:0]      pc, pc_nxt, addr_nxt, pc_inc, redir_pc_eff;
  entry_t                     mem [DEPTH];
  entry_t                     push_ent;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0]              count, count_after_push;
  logic                       push, pop, flush, has_space;

  assign out_valid        = (count != '0);
  assign pop              = out_valid & out_ready;
  assign has_space        = (count < DEPTH_C);
  assign count_after_push = count + CW'(1) - CW'(pop);
  assign pc_inc           = pc + ADDR_WIDTH'(4);
  assign icache_read_en   = (state == REQ) || (state == DISCARD);

  assign out_pc   = mem[rd_ptr].pc;
  assign out_inst = mem[rd_ptr].inst;
`ifdef FETCH_ALIGN_CHECK_EN
  assign out_adel = mem[rd_ptr].adel;
  assign redir_pc_eff = redirect_pc;
`else
  assign redir_pc_eff = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
`endif

  // A redirect overrides everything; an unanswered request must still be drained in DISCARD.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    addr_nxt  = icache_addr;
    push      = 1'b0;
    push_ent  = '0;
    flush     = 1'b0;
    if (redirect_en) begin
      flush  = 1'b1;
      pc_nxt = redir_pc_eff;
      if ((state == REQ || state == DISCARD) && !icache_ready) state_nxt = DISCARD;
      else                                                      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (has_space) begin
            addr_nxt  = pc;
            state_nxt = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
              addr_nxt      = icache_addr;
              state_nxt     = HALT;
              push          = 1'b1;
              push_ent.pc   = pc;
              push_ent.adel = 1'b1;
            end
`endif
          end
        end
        REQ: begin
          if (icache_ready) begin
            push          = 1'b1;
            push_ent.pc   = icache_addr;
            push_ent.inst = icache_data;
            pc_nxt        = pc_inc;
            if (count_after_push < DEPTH_C) addr_nxt  = pc_inc;
            else                            state_nxt = IDLE;
          end
        end
        DISCARD: begin
          if (icache_ready) state_nxt = IDLE;
        end
        HALT: state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      icache_addr <= RESET_PC;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      icache_addr <= addr_nxt;
    end
  end

  // Flush wins over push and pop in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_ent;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboarded bench for fetch_unit: bench-side cache model plus a fetch-stream reference model.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        icache_read_en;
  logic [31:0] icache_addr;
  logic        icache_ready = 1'b0;
  logic [31:0] icache_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        out_adel;
`endif

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .icache_read_en(icache_read_en), .icache_addr(icache_addr),
    .icache_ready(icache_ready), .icache_data(icache_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
`ifdef FETCH_ALIGN_CHECK_EN
    , .out_adel(out_adel)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adel; } ent_t;
  ent_t expq[$];
  int checks = 0, failures = 0;

  // cache model / reference fetch stream
  bit          outstanding = 0, stale = 0, new_req = 0;
  logic [31:0] req_addr = '0, last_req_addr = '0, next_pc = RST_PC;
  int          lat_left = 0, delivered = 0, req_count = 0, adel_wait = 0, adel_popped = 0;
  logic [31:0] adel_pc = '0;
  bit          pend_push = 0, pend_flush = 0;
  ent_t        pend_ent;
  // stimulus knobs
  int          lat_min = 0, lat_max = 0, rdy_pct = 0, redir_pct = 0;
  bit          force_redir = 0, redir_on_ready = 0;
  logic [31:0] force_target = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic push_exp(input ent_t e);
    chk("fifo_capacity", 32'(expq.size() < 8), 32'd1);
    expq.push_back(e);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(3))
      0: t = 32'h80000180;
      1: t = 32'hfffffff8;
      2: t = 32'h00000000;
      default: t = $urandom & 32'hfffffffc;
    endcase
    return t;
  endfunction

  task automatic cycle();
    bit          do_redir;
    logic [31:0] target;
    @(posedge clk);
    if (pend_flush) expq.delete();
    if (pend_push) push_exp(pend_ent);
    pend_push  = 0;
    pend_flush = 0;
    if (icache_ready) begin outstanding = 0; stale = 0; end
    if (adel_wait == 2) begin
      push_exp('{adel_pc, 32'h0, 1'b1});
      adel_wait = 0;
    end else if (adel_wait == 1 && !outstanding) adel_wait = 2;
    #1;
    icache_ready = 1'b0;
    redirect_en  = 1'b0;
    new_req      = 0;
    out_ready    = ($urandom_range(99) < rdy_pct);
    if (!outstanding && icache_read_en) begin
`ifdef FETCH_ALIGN_CHECK_EN
      chk("no_req_while_halted", {30'b0, next_pc[1:0]}, 32'd0);
`endif
      chk("req_addr", icache_addr, next_pc);
      outstanding   = 1;
      stale         = 0;
      req_addr      = icache_addr;
      last_req_addr = icache_addr;
      new_req       = 1;
      req_count++;
      lat_left      = int'($urandom_range(lat_max, lat_min));
    end else if (outstanding) begin
      chk("req_hold_en", {31'b0, icache_read_en}, 32'd1);
      chk("req_hold_addr", icache_addr, req_addr);
    end
    if (outstanding) begin
      if (lat_left == 0) begin icache_ready = 1'b1; icache_data = $urandom; end
      else lat_left--;
    end
    do_redir = 0;
    target   = '0;
    if (force_redir) begin
      do_redir = 1; target = force_target; force_redir = 0;
    end else if (redir_on_ready && icache_ready && !stale) begin
      do_redir = 1; target = force_target; redir_on_ready = 0;
    end else if ($urandom_range(99) < redir_pct) begin
      do_redir = 1; target = pick_target();
    end
    if (do_redir) begin
      redirect_en = 1'b1;
      redirect_pc = target;
      pend_flush  = 1;
      if (outstanding) stale = 1;
`ifdef FETCH_ALIGN_CHECK_EN
      next_pc = target;
      if (target[1:0] != 2'b00) begin adel_wait = 1; adel_pc = target; end
      else adel_wait = 0;
`else
      next_pc = {target[31:2], 2'b00};
`endif
    end else if (icache_ready && !stale) begin
      pend_push = 1;
      pend_ent  = '{req_addr, icache_data, 1'b0};
      next_pc   = req_addr + 32'd4;
      delivered++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_req(input string name, input logic [31:0] exp);
    int n = 0;
    do begin cycle(); n++; end while (!new_req && n < 100);
    if (!new_req) begin
      checks++; failures++;
      $display("FAIL %s timeout waiting for request (expected addr %h)", name, exp);
    end else chk(name, last_req_addr, exp);
  endtask

  // Monitor: the DUT head must always match the scoreboard front.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("out_valid", {31'b0, out_valid}, 32'(expq.size() != 0));
        if (out_valid && expq.size() != 0) begin
          chk("out_pc", out_pc, expq[0].pc);
          chk("out_inst", out_inst, expq[0].inst);
`ifdef FETCH_ALIGN_CHECK_EN
          chk("out_adel", {31'b0, out_adel}, {31'b0, expq[0].adel});
`endif
          if (out_ready) begin
            if (expq[0].adel) adel_popped++;
            void'(expq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n;
    int d0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_read_en", {31'b0, icache_read_en}, 32'd0);
    chk("rst_addr", icache_addr, RST_PC);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Decode stalled, cache answers immediately: exactly eight entries fill the FIFO.
    d0 = delivered;
    run(30);
    chk("fill_count", 32'(delivered - d0), 32'd8);
    chk("fill_stop_read_en", {31'b0, icache_read_en}, 32'd0);
    rdy_pct = 100;
    wait_req("resume_addr", 32'hbfc00020);
    run(10);

    // Redirect while a request is waiting: late response dropped, refetch after it.
    lat_min = 4; lat_max = 4;
    n = 0;
    do begin cycle(); n++; end while (!new_req && n < 100);
    force_redir = 1; force_target = 32'h80000180;
    cycle();
    cycle();
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    wait_req("redir_req_addr", 32'h80000180);
    run(15);

    // Redirect coinciding with the response.
    lat_min = 1; lat_max = 1;
    redir_on_ready = 1; force_target = 32'h00001000;
    n = 0;
    do begin cycle(); n++; end while (redir_on_ready && n < 100);
    wait_req("same_cycle_redir_addr", 32'h00001000);
    run(10);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned target: one address-error entry, then fetch halts.
    lat_min = 0; lat_max = 2;
    force_redir = 1; force_target = 32'h80000002;
    cycle();
    n = req_count;
    run(25);
    chk("halt_no_requests", 32'(req_count - n), 32'd0);
    chk("adel_entries", 32'(adel_popped), 32'd1);
    force_redir = 1; force_target = 32'h80000100;
    wait_req("halt_resume_addr", 32'h80000100);
`else
    // Low PC bits are discarded on redirect.
    force_redir = 1; force_target = 32'h80000182;
    wait_req("redir_mask_addr", 32'h80000180);
`endif
    run(10);

    // Reset pulse mid-request, then the two-cycle-latency sequential stream.
    lat_min = 2; lat_max = 2;
    n = 0;
    do begin cycle(); n++; end while (!outstanding && n < 100);
    rst = 1'b0;
    icache_ready = 1'b0; redirect_en = 1'b0;
    expq.delete();
    outstanding = 0; stale = 0; pend_push = 0; pend_flush = 0; adel_wait = 0;
    next_pc = RST_PC;
    #1;
    chk("midrst_read_en", {31'b0, icache_read_en}, 32'd0);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    wait_req("rst_restart_addr", RST_PC);
    wait_req("seq_addr_1", 32'hbfc00004);
    wait_req("seq_addr_2", 32'hbfc00008);
    run(10);

    // Randomized traffic.
    lat_min = 0; lat_max = 4; rdy_pct = 70; redir_pct = 3;
    run(2000);
    redir_pct = 0; rdy_pct = 100;
    run(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
